motor_pwm_stage: RTL



---
 rtl/motor_pwm_stage_if.sv | 9 +
 rtl/motor_pwm_stage.sv | 90 +++++++++
 2 files changed

// File: rtl/motor_pwm_stage_if.sv
// motor_pwm_stage_if: direction inputs, requested duty and H-bridge drive for motor_pwm_stage
// master drives m1_in/m2_in/duty_in and observes m1_pwm/m2_pwm/dead_active/fault; slave is the stage itself.
interface motor_pwm_stage_if #(parameter int CNT_W = 8);
  logic [3:0] m1_in, m2_in, m1_pwm, m2_pwm;
  logic [CNT_W-1:0] duty_in;
  logic dead_active, fault;
  modport master(output m1_in, m2_in, duty_in, input m1_pwm, m2_pwm, dead_active, fault);
  modport slave(input m1_in, m2_in, duty_in, output m1_pwm, m2_pwm, dead_active, fault);
endinterface

// File: rtl/motor_pwm_stage.sv
// motor_pwm_stage: PWM gating, dead-time on reversal, shoot-through blocking and optional soft start for two H-bridges
// Ports: clk, rst (async, active-high); bus (slave) carries m1_in/m2_in/duty_in in and m1_pwm/m2_pwm/dead_active/fault out.
// Macro MOTOR_SOFTSTART_EN: when defined, duty ramps up one LSB every RAMP_DIV clocks after each start; otherwise duty follows duty_in.
module motor_pwm_stage #(
  parameter int CNT_W = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int RAMP_DIV = 256
) (
  input logic clk,
  input logic rst,
  motor_pwm_stage_if.slave bus
);
  localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  logic [CNT_W-1:0] cnt;
  logic dead_q;
  // period is 2^CNT_W-1 so that duty all-ones means always on
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt == CNT_W'(2 ** CNT_W - 2) ? '0 : cnt + 1'b1;
`ifdef MOTOR_SOFTSTART_EN
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  logic [PW-1:0] pre;
  logic tick;
  assign tick = pre == PW'(RAMP_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
`endif
  for (genvar c = 0; c < 2; c++) begin : ch
    logic [3:0] raw, in, pat, pat_n, pwm, pwm_n;
    state_t st, st_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [CNT_W-1:0] duty_n;
    assign raw = c == 0 ? bus.m1_in : bus.m2_in;
    // shoot-through patterns are treated as stop
    assign in = raw[3:2] == 2'b11 || raw[1:0] == 2'b11 ? 4'b0 : raw;
    always_comb begin
      st_n = st;
      pat_n = pat;
      dcnt_n = dcnt;
      if (st == IDLE) begin
        if (in != 4'b0) begin
          st_n = RUN;
          pat_n = in;
        end
      end else if (in == 4'b0) st_n = IDLE;
      else if (in != pat) begin
        st_n = DEAD;
        pat_n = in;
        dcnt_n = DW'(DEAD_CYCLES - 1);
      end else if (st == DEAD) begin
        if (dcnt == '0) st_n = RUN;
        else dcnt_n = dcnt - 1'b1;
      end
    end
`ifdef MOTOR_SOFTSTART_EN
    logic [CNT_W-1:0] duty;
    // duty restarts from 0 on every entry into RUN, snaps down at once, creeps up on ticks
    assign duty_n = st != RUN || st_n != RUN ? '0 :
                    bus.duty_in < duty ? bus.duty_in :
                    tick && duty < bus.duty_in ? duty + 1'b1 : duty;
    always_ff @(posedge clk or posedge rst)
      if (rst) duty <= '0;
      else duty <= duty_n;
`else
    assign duty_n = bus.duty_in;
`endif
    assign pwm_n = st_n == RUN && cnt < duty_n ? pat_n : 4'b0;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st <= IDLE;
        pat <= '0;
        dcnt <= '0;
        pwm <= '0;
      end else begin
        st <= st_n;
        pat <= pat_n;
        dcnt <= dcnt_n;
        pwm <= pwm_n;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) dead_q <= 1'b0;
    else dead_q <= ch[0].st_n == DEAD || ch[1].st_n == DEAD;
  assign bus.m1_pwm = ch[0].pwm;
  assign bus.m2_pwm = ch[1].pwm;
  assign bus.dead_active = dead_q;
  assign bus.fault = &bus.m1_in[3:2] | &bus.m1_in[1:0] | &bus.m2_in[3:2] | &bus.m2_in[1:0];
endmodule
